// File: rtl/pipe_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: hazard detection,
// mult/div occupancy tracking, syscall freeze and per-register enable/clear generation.
module pipe_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      D_rs,
    input  logic [4:0]      D_rt,
    input  logic            D_use_rs,
    input  logic            D_use_rt,
    input  logic            D_branch,
    input  logic            D_jump_taken,
    input  logic            D_md_start,
    input  logic            D_md_use,
    input  logic [4:0]      E_RW,
    input  logic            E_RegWrite,
    input  logic            E_MemRead,
    input  logic            E_md_start,
    input  logic [4:0]      M_RW,
    input  logic            M_MemRead,
    input  logic            W_syscall,
    input  logic            go,
    output logic            pc_en,
    output logic            FD_en,
    output logic            FD_clr,
    output logic            DE_en,
    output logic            DE_clr,
    output logic            EM_en,
    output logic            MW_en,
    output logic            halted,
    output logic            md_busy,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state_q;
    logic [3:0]      md_cnt_q;
    logic [CNTW-1:0] stall_cnt_q;

    logic hz;
    logic mds;
    logic stall;

    // A D-stage source operand that is actually read matches r; $0 never hazards.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       use_rs,
                                       input logic       use_rt);
        return (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    function automatic logic [3:0] md_next(input logic [3:0] cnt, input logic start);
        if (start)
            return MD_LOAD;
        else if (cnt != 4'd0)
            return cnt - 4'd1;
        else
            return cnt;
    endfunction

    always_comb begin
        hz = (E_MemRead && reg_match(E_RW, D_rs, D_rt, D_use_rs, D_use_rt))
          || (D_branch && E_RegWrite && reg_match(E_RW, D_rs, D_rt, D_use_rs, D_use_rt))
          || (D_branch && M_MemRead && reg_match(M_RW, D_rs, D_rt, D_use_rs, D_use_rt));
        mds   = (md_cnt_q != 4'd0) && (D_md_use || D_md_start);
        stall = hz || mds;
    end

    always_comb begin
        pc_en  = 1'b0;
        FD_en  = 1'b0;
        FD_clr = 1'b0;
        DE_en  = 1'b0;
        DE_clr = 1'b0;
        EM_en  = 1'b0;
        MW_en  = 1'b0;
        case (state_q)
            RUN: begin
                if (W_syscall) begin
                    // Freeze everything; the syscall owns the machine.
                end else if (stall) begin
                    DE_en  = 1'b1;
                    DE_clr = 1'b1;
                    EM_en  = 1'b1;
                    MW_en  = 1'b1;
                end else begin
                    pc_en  = 1'b1;
                    FD_en  = 1'b1;
                    FD_clr = D_jump_taken;
                    DE_en  = 1'b1;
                    EM_en  = 1'b1;
                    MW_en  = 1'b1;
                end
            end
            HALT: begin
                if (go) begin
                    pc_en = 1'b1;
                    FD_en = 1'b1;
                    DE_en = 1'b1;
                    EM_en = 1'b1;
                    MW_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Counters only advance in RUN; HALT holds them for post-mortem inspection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    md_cnt_q <= md_next(md_cnt_q, E_md_start);
                    if (W_syscall)
                        state_q <= HALT;
                    else if (stall)
                        stall_cnt_q <= sat_inc(stall_cnt_q);
                end
                HALT: begin
                    if (go)
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign halted    = (state_q == HALT);
    assign md_busy   = (md_cnt_q != 4'd0);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/halt sequencer for the 5-stage MIPS pipeline.
- Drives the enable and clear inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Detects load-use and branch-operand hazards and tracks multi-cycle mult/div occupancy.
- Freezes the machine when a syscall reaches W and resumes it on a `go` pulse.

Parameters:
- MD_LAT, 4: cycles the mult/div unit stays busy after a start (1..15).
- CNTW, 32: width of the stall statistics counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- D_rs, input, 5: rs field of the instruction in D.
- D_rt, input, 5: rt field of the instruction in D.
- D_use_rs, input, 1: D instruction reads rs.
- D_use_rt, input, 1: D instruction reads rt.
- D_branch, input, 1: D instruction is a branch or jr that compares or uses registers in D.
- D_jump_taken, input, 1: D resolves a taken branch or jump.
- D_md_start, input, 1: D instruction is mult/div.
- D_md_use, input, 1: D instruction is mfhi/mflo.
- E_RW, input, 5: destination register in E.
- E_RegWrite, input, 1: E writes the register file.
- E_MemRead, input, 1: E is a load.
- E_md_start, input, 1: mult/div instruction currently in E.
- M_RW, input, 5: destination register in M.
- M_MemRead, input, 1: M is a load.
- W_syscall, input, 1: syscall in W.
- go, input, 1: resume request, level-sampled.
- pc_en, output, 1: PC enable.
- FD_en, output, 1: IF_ID enable.
- FD_clr, output, 1: IF_ID clear.
- DE_en, output, 1: ID_EX enable.
- DE_clr, output, 1: ID_EX clear.
- EM_en, output, 1: EX_MEM enable.
- MW_en, output, 1: MEM_WB enable.
- halted, output, 1: state is HALT.
- md_busy, output, 1: mult/div counter nonzero.
- stall_cnt, output, CNTW: count of stalled cycles.

Behaviour:
- Register match: `match(r) = (r != 0) && ((r == D_rs && D_use_rs) || (r == D_rt && D_use_rt))`.
- Hazard stall (`hz`):
  - `E_MemRead && match(E_RW)`, or
  - `D_branch && E_RegWrite && match(E_RW)`, or
  - `D_branch && M_MemRead && match(M_RW)`.
- Mult/div stall (`mds`): `md_busy && (D_md_use || D_md_start)`.
- Stall: `stall = hz || mds`.
- States: RUN and HALT, 1 flop. Reset puts the block in RUN with md counter = 0 and stall_cnt = 0.
- RUN, W_syscall=1:
  - All enables 0, all clears 0.
  - Next state HALT.
  - Takes priority over stall and flush; stall_cnt does not increment.
- RUN, stall=1:
  - pc_en=0, FD_en=0, FD_clr=0, DE_en=1, DE_clr=1 (bubble into E), EM_en=1, MW_en=1.
  - D_jump_taken is ignored; the D instruction re-evaluates next cycle.
  - stall_cnt increments, saturating at all-ones.
- RUN, no stall, D_jump_taken=1: all enables 1, FD_clr=1 (no delay slot; the fetched instruction is squashed), DE_clr=0.
- RUN, otherwise: all enables 1, clears 0.
- HALT:
  - go=0: all enables 0, clears 0; stall_cnt and the md counter are frozen.
  - go=1: that cycle all enables 1 and clears 0, W_syscall is ignored, next state RUN. The syscall leaves W, so there is no re-trigger.
- go is ignored in RUN.
- Mult/div counter (4 bits), in RUN only:
  - E_md_start=1 loads MD_LAT. This takes priority over decrement and also reloads if the counter is nonzero.
  - Otherwise the counter decrements if nonzero.
- md_busy = (counter != 0). It is the registered value; the busy window starts the cycle after E_md_start.
- All outputs except halted, md_busy and stall_cnt are combinational from state and inputs.
- halted, md_busy and stall_cnt derive from registers only.
- Reset mid-operation: asserting rst_n low at any time returns immediately to RUN with counters cleared. Enables then follow the RUN equations with current inputs.
- Register 0 never causes a hazard.

Test Plan:
- Load-use: E_MemRead=1, E_RW=8, D_rs=8, D_use_rs=1 → pc_en=0, FD_en=0, DE_clr=1 for 1 cycle; stall_cnt 0→1. With E_RW=0 instead → no stall.
- Branch after ALU op: D_branch=1, D_rt=5, D_use_rt=1, E_RegWrite=1, E_RW=5 → stall. Next cycle the instruction is in M with M_MemRead=0 → no stall.
- Taken jump: D_jump_taken=1 with no hazard → FD_clr=1, all enables 1. With a simultaneous load-use hazard → FD_clr=0, stall outputs apply.
- Mult/div: E_md_start pulse with MD_LAT=4 → md_busy high 4 cycles. D_md_use held → 4 stall cycles, then release; stall_cnt=4.
- Syscall: W_syscall=1 → all enables 0 that cycle, halted=1 next cycle. Hold go=0 for 10 cycles → outputs stay 0, stall_cnt and md counter unchanged. go=1 → enables 1, halted=0 next cycle.
- Reset: assert rst_n=0 during HALT with md_busy=1 → halted=0, md_busy=0, stall_cnt=0 immediately, without waiting for a clock edge.
